// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared definitions for the iterative divider: default
//                operand width, FSM state encoding and the most-negative
//                two's-complement value used by the overflow special case.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One restoring shift-subtract step (combinational).
//                Shifts the next dividend bit into the partial remainder,
//                trial-subtracts the divisor and restores on borrow.
//  Ports       : rem_in   - partial remainder, DATA_WIDTH+1 bits
//                divisor  - divisor magnitude
//                dvd_bit  - next dividend bit (MSB first)
//                rem_out  - updated partial remainder
//                q_bit    - quotient bit produced by this step
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   rem_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  dvd_bit,
    output logic [DATA_WIDTH:0]   rem_out,
    output logic                  q_bit
);

    logic [DATA_WIDTH+1:0] w_shift;
    logic [DATA_WIDTH+1:0] w_diff;
    logic                  w_neg;

    // The partial remainder is always below the divisor, so after the shift
    // it stays below 2^(DATA_WIDTH+1); the top bit of the difference is then
    // a reliable borrow indicator.
    assign w_shift = {rem_in, dvd_bit};
    assign w_diff  = w_shift - {2'b00, divisor};
    assign w_neg   = w_diff[DATA_WIDTH+1];

    assign rem_out = w_neg ? w_shift[DATA_WIDTH:0] : w_diff[DATA_WIDTH:0];
    assign q_bit   = ~w_neg;

endmodule : div_step
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
//  Module      : divider
//  Description : Multi-cycle signed/unsigned integer divider, one restoring
//                step per clock, valid/ready on both request and result.
//                Quotient truncates toward zero, remainder follows the sign
//                of the dividend. Divide-by-zero and signed MIN/-1 are
//                resolved at accept without iterating.
//  Ports       : clk, resetn (async, active low)
//                in_valid/in_ready, A, B, Signed  - request side
//                out_valid/out_ready, Quotient, Remainder,
//                DivZero, Overflow                - result side
//  Revision    : 1.0 - initial release
// ============================================================================
module divider
    import div_pkg::state_t, div_pkg::IDLE, div_pkg::CALC, div_pkg::DONE;
#(
    parameter int DATA_WIDTH = div_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Quotient,
    output logic [DATA_WIDTH-1:0] Remainder,
    output logic                  DivZero,
    output logic                  Overflow
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]      c_cnt_load = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]      c_cnt_one  = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] c_int_min  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_dvd;      // dividend magnitude, quotient bits shift in at the bottom
    logic [DATA_WIDTH-1:0] r_dvs;      // divisor magnitude
    logic [DATA_WIDTH:0]   r_prem;     // partial remainder
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_qneg;
    logic                  r_rneg;
    logic                  r_bypass;   // special case: result already loaded at accept
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_rem;
    logic                  r_dz;
    logic                  r_ov;

    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_abs_a;
    logic [DATA_WIDTH-1:0] w_abs_b;
    logic                  w_div0;
    logic                  w_ovf;
    logic [DATA_WIDTH:0]   w_prem_next;
    logic                  w_qbit;
    logic [DATA_WIDTH-1:0] w_quo_raw;
    logic [DATA_WIDTH-1:0] w_rem_raw;

    assign w_a_neg = Signed & A[DATA_WIDTH-1];
    assign w_b_neg = Signed & B[DATA_WIDTH-1];
    // Negating MIN yields MIN, which read as unsigned is the correct magnitude.
    assign w_abs_a = w_a_neg ? -A : A;
    assign w_abs_b = w_b_neg ? -B : B;
    assign w_div0  = (B == '0);
    assign w_ovf   = Signed && (A == c_int_min) && (B == '1);

    div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem_in  (r_prem),
        .divisor (r_dvs),
        .dvd_bit (r_dvd[DATA_WIDTH-1]),
        .rem_out (w_prem_next),
        .q_bit   (w_qbit)
    );

    // Final-step view: last quotient bit appended, remainder fits DATA_WIDTH.
    assign w_quo_raw = {r_dvd[DATA_WIDTH-2:0], w_qbit};
    assign w_rem_raw = w_prem_next[DATA_WIDTH-1:0];

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign Quotient  = r_quo;
    assign Remainder = r_rem;
    assign DivZero   = r_dz;
    assign Overflow  = r_ov;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_prem   <= '0;
            r_cnt    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_bypass <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dz     <= 1'b0;
            r_ov     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dz     <= 1'b0;
                        r_ov     <= 1'b0;
                        r_bypass <= 1'b0;
                        r_state  <= CALC;
                        if (w_div0) begin
                            r_quo    <= '1;
                            r_rem    <= A;
                            r_dz     <= 1'b1;
                            r_bypass <= 1'b1;
                        end else if (w_ovf) begin
                            r_quo    <= c_int_min;
                            r_rem    <= '0;
                            r_ov     <= 1'b1;
                            r_bypass <= 1'b1;
                        end else begin
                            r_dvd  <= w_abs_a;
                            r_dvs  <= w_abs_b;
                            r_qneg <= w_a_neg ^ w_b_neg;
                            r_rneg <= w_a_neg;
                            r_prem <= '0;
                            r_cnt  <= c_cnt_load;
                        end
                    end
                end

                CALC: begin
                    // Special cases spend exactly one cycle here so their
                    // result appears one edge after accept.
                    if (r_bypass) begin
                        r_state <= DONE;
                    end else begin
                        r_prem <= w_prem_next;
                        r_dvd  <= w_quo_raw;
                        r_cnt  <= r_cnt - c_cnt_one;
                        if (r_cnt == '0) begin
                            r_quo   <= r_qneg ? -w_quo_raw : w_quo_raw;
                            r_rem   <= r_rneg ? -w_rem_raw : w_rem_raw;
                            r_state <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : divider
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider
//  Description : Self-checking bench for divider. A monitor process captures
//                every accepted request, predicts the result with plain
//                integer arithmetic and checks outputs, flags and latency
//                on every cycle the result is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider;
    import div_pkg::*;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         resetn    = 1'b0;
    logic         in_valid  = 1'b0;
    logic         Signed    = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] A         = '0;
    logic [W-1:0] B         = '0;
    logic         in_ready;
    logic         out_valid;
    logic         DivZero;
    logic         Overflow;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;

    divider #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Signed    (Signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivZero   (DivZero),
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
        int           acc;
    } exp_t;

    exp_t expq[$];
    bit   first_seen = 1'b0;

    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic s);
        exp_t   e;
        longint sa;
        longint sb;
        longint sq;
        longint sr;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        e.lat = W;
        e.acc = 0;
        e.q   = '0;
        e.r   = '0;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else if (s && a == INT_MIN && b == '1) begin
            e.q = INT_MIN; e.r = '0; e.ov = 1'b1; e.lat = 1;
        end else if (s) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            sq  = sa / sb;
            sr  = sa % sb;
            e.q = sq[W-1:0];
            e.r = sr[W-1:0];
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor / scoreboard: everything sampled on the falling edge.
    always @(negedge clk) begin : p_cmp
        exp_t e;
        if (!resetn) begin
            expq.delete();
            first_seen = 1'b0;
        end else begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    if (!first_seen) begin
                        chk("latency", 64'(cyc - expq[0].acc), 64'(expq[0].lat));
                        first_seen = 1'b1;
                    end
                    chk("Quotient",  {32'd0, Quotient},  {32'd0, expq[0].q});
                    chk("Remainder", {32'd0, Remainder}, {32'd0, expq[0].r});
                    chk("DivZero",   {63'd0, DivZero},   {63'd0, expq[0].dz});
                    chk("Overflow",  {63'd0, Overflow},  {63'd0, expq[0].ov});
                    chk("in_ready in DONE", {63'd0, in_ready}, 64'd0);
                    if (out_ready) begin
                        void'(expq.pop_front());
                        first_seen = 1'b0;
                    end
                end
            end else if (expq.size() != 0 && (cyc - expq[0].acc) > W + 4) begin
                chk("result timeout", {63'd0, out_valid}, 64'd1);
                void'(expq.pop_front());
                first_seen = 1'b0;
            end
            if (in_valid && in_ready) begin
                e     = model(A, B, Signed);
                e.acc = cyc + 1;
                expq.push_back(e);
            end
        end
    end

    // Present a request and hold it until the accepting edge.
    task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic s);
        int k;
        A = a; B = b; Signed = s; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 2 * W) begin
            @(posedge clk); #2; k++;
        end
        if (!in_ready) chk("accept timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; Signed = 1'($urandom_range(0, 1));
    endtask

    // Full transaction; hold > 0 keeps out_ready low that many DONE cycles
    // while junk is driven on the request side.
    task automatic run(logic [W-1:0] a, logic [W-1:0] b, logic s, int hold);
        int k;
        issue(a, b, s);
        k = 0;
        while (!out_valid && k < W + 8) begin
            @(posedge clk); #2; k++;
        end
        if (!out_valid) chk("out_valid timeout", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            A = $urandom; B = $urandom; Signed = 1'($urandom_range(0, 1));
            @(posedge clk); #2;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

    initial begin : p_main
        exp_t         e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sel;

        // Pin the reference model to hand-computed values.
        e = model(32'd100, 32'd7, 1'b0);
        chk("model 100/7 q", {32'd0, e.q}, 64'd14);
        chk("model 100/7 r", {32'd0, e.r}, 64'd2);
        e = model(32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("model -7/2 q", {32'd0, e.q}, 64'hFFFF_FFFD);
        chk("model -7/2 r", {32'd0, e.r}, 64'hFFFF_FFFF);
        e = model(32'd7, 32'hFFFF_FFFE, 1'b1);
        chk("model 7/-2 q", {32'd0, e.q}, 64'hFFFF_FFFD);
        chk("model 7/-2 r", {32'd0, e.r}, 64'd1);
        e = model(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("model umin/max q", {32'd0, e.q}, 64'd0);
        chk("model umin/max r", {32'd0, e.r}, 64'h8000_0000);
        e = model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        chk("model smin/-1 ov", {63'd0, e.ov}, 64'd1);
        e = model(32'd5, 32'd0, 1'b1);
        chk("model 5/0 q", {32'd0, e.q}, 64'hFFFF_FFFF);
        chk("model 5/0 r", {32'd0, e.r}, 64'd5);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready",  {63'd0, in_ready},  64'd1);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset Quotient",  {32'd0, Quotient},  64'd0);
        chk("reset Remainder", {32'd0, Remainder}, 64'd0);
        chk("reset flags",     {62'd0, DivZero, Overflow}, 64'd0);
        @(posedge clk); #2;
        resetn = 1'b1;
        @(posedge clk); #2;

        // Directed cases.
        run(32'd100,       32'd7,           1'b0, 0);
        run(32'hFFFF_FFF9, 32'd2,           1'b1, 0);
        run(32'd7,         32'hFFFF_FFFE,   1'b1, 0);
        run(32'hFFFF_FFFF, 32'd1,           1'b0, 0);
        run(32'd5,         32'd0,           1'b0, 0);
        run(32'd5,         32'd0,           1'b1, 0);
        run(32'h8000_0000, 32'hFFFF_FFFF,   1'b1, 0);
        run(32'h8000_0000, 32'hFFFF_FFFF,   1'b0, 0);
        run(32'h8000_0000, 32'd3,           1'b1, 0);

        // Backpressure, then a normal request afterwards.
        run(32'hFFFF_FC18, 32'd33, 1'b1, 10);
        run(32'd12345,     32'd678, 1'b0, 0);

        // Reset in the middle of an iteration.
        issue(32'd100, 32'd7, 1'b0);
        repeat (16) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("midreset in_ready",  {63'd0, in_ready},  64'd1);
        chk("midreset out_valid", {63'd0, out_valid}, 64'd0);
        chk("midreset Quotient",  {32'd0, Quotient},  64'd0);
        chk("midreset Remainder", {32'd0, Remainder}, 64'd0);
        chk("midreset flags",     {62'd0, DivZero, Overflow}, 64'd0);
        @(posedge clk); #2;
        resetn = 1'b1;
        @(posedge clk); #2;
        run(32'd100, 32'd7, 1'b0, 0);

        // Randomized traffic with a bias toward boundary operands.
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            rb  = $urandom;
            case (sel)
                0:       rb = '0;
                1:       rb = '1;
                2:       rb = W'($urandom_range(1, 16));
                3:       ra = INT_MIN;
                4:       begin ra = INT_MIN; rb = '1; end
                5:       ra = W'($urandom_range(0, 50));
                default: ;
            endcase
            run(ra, rb, 1'($urandom_range(0, 1)), (n % 7 == 0) ? 3 : 0);
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_divider
`default_nettype wire
